pueo_run_sequencer: RTL

- Sequences the run-control flags (do-sync, reset, stop) from the command decoder into a run state machine on SYSCLK.
- Applies a programmable SYSCLK delay to each sync and reset so every SURF acts on the same clock edge.
- Stretches the run reset to a fixed hold time, tracks run state, and counts runs.
- Sits between the command decoder and the trigger/readout datapath, which uses `run_rst_o`, `sync_o` and `running_o`.

---
 rtl/pueo_run_pkg.sv | 21 ++
 rtl/pueo_run_sequencer_if.sv | 26 ++
 rtl/pueo_run_delay_counter.sv | 36 +++
 rtl/pueo_run_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pueo_run_pkg.sv
// Shared run-control types: state encoding seen on state_o and the counter
// width helper used by the sequencer.
package pueo_run_pkg;

    typedef enum logic [2:0] {
        RUN_STATE_IDLE      = 3'd0,
        RUN_STATE_SYNC_WAIT = 3'd1,
        RUN_STATE_SYNCED    = 3'd2,
        RUN_STATE_RST_WAIT  = 3'd3,
        RUN_STATE_RST_HOLD  = 3'd4,
        RUN_STATE_RUNNING   = 3'd5
    } run_state_t;

    // One counter serves both the alignment delay and the reset hold.
    function automatic int count_width(input int delay_bits, input int reset_hold);
        int hold_bits;
        hold_bits = $clog2(reset_hold + 1);
        return (delay_bits > hold_bits) ? delay_bits : hold_bits;
    endfunction

endpackage

// File: rtl/pueo_run_sequencer_if.sv
// Command-decoder side flags and datapath-side run status of the run sequencer.
interface pueo_run_sequencer_if #(
    parameter int DELAY_BITS = 8,
    parameter int RUNID_BITS = 16
);
    logic                  rundosync_i;
    logic                  runrst_i;
    logic                  runstop_i;
    logic [DELAY_BITS-1:0] delay_i;
    logic                  sync_o;
    logic                  run_rst_o;
    logic                  running_o;
    logic [2:0]            state_o;
    logic [RUNID_BITS-1:0] run_id_o;
    logic                  cmd_err_o;

    modport slave (
        input  rundosync_i, runrst_i, runstop_i, delay_i,
        output sync_o, run_rst_o, running_o, state_o, run_id_o, cmd_err_o
    );

    modport master (
        output rundosync_i, runrst_i, runstop_i, delay_i,
        input  sync_o, run_rst_o, running_o, state_o, run_id_o, cmd_err_o
    );
endinterface

// File: rtl/pueo_run_delay_counter.sv
// Loadable down-counter; counts to zero and parks there until reloaded.
module pueo_run_delay_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             done_o,
    output logic             busy_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == '0);
    assign busy_o  = (count_q != '0);
endmodule

// File: rtl/pueo_run_sequencer.sv
// Run-control sequencer: aligns sync/reset to a programmable SYSCLK delay,
// stretches the run reset and counts runs.
//   state      | meaning
//   IDLE       | no run, waiting for a sync
//   SYNC_WAIT  | alignment delay before sync_o
//   SYNCED     | synced, waiting for a run reset
//   RST_WAIT   | alignment delay before run_rst_o
//   RST_HOLD   | run_rst_o asserted for RESET_HOLD cycles
//   RUNNING    | run in progress
module pueo_run_sequencer
    import pueo_run_pkg::*;
#(
    parameter int DELAY_BITS = 8,
    parameter int RESET_HOLD = 16,
    parameter int RUNID_BITS = 16
) (
    input  logic                 sysclk_i,
    input  logic                 rst_n_i,
    pueo_run_sequencer_if.slave  run_bus
);
    localparam int CNT_W = count_width(DELAY_BITS, RESET_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD - 1);

    run_state_t            state_q, state_d;
    logic                  sync_q, sync_d;
    logic                  run_rst_q, run_rst_d;
    logic                  running_q, running_d;
    logic                  err_q, err_d;
    logic [RUNID_BITS-1:0] run_id_q, run_id_d;

    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_load_val;
    logic [CNT_W-1:0]      cnt_value;
    logic                  cnt_done;
    logic                  cnt_busy;
    logic [CNT_W-1:0]      dly;
    logic                  dly_zero;

    assign dly      = CNT_W'(run_bus.delay_i);
    assign dly_zero = (run_bus.delay_i == '0);

    pueo_run_delay_counter #(.WIDTH(CNT_W)) u_delay_counter (
        .clk_i      (sysclk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .count_o    (cnt_value),
        .done_o     (cnt_done),
        .busy_o     (cnt_busy)
    );

    always_comb begin
        state_d      = state_q;
        sync_d       = 1'b0;
        err_d        = 1'b0;
        run_id_d     = run_id_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        case (state_q)
            RUN_STATE_SYNC_WAIT: begin
                sync_d = cnt_busy && (cnt_value == CNT_W'(1));
                if (cnt_done) state_d = RUN_STATE_SYNCED;
            end
            RUN_STATE_RST_WAIT: begin
                if (cnt_done) begin
                    state_d      = RUN_STATE_RST_HOLD;
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_LOAD;
                end
            end
            RUN_STATE_RST_HOLD: begin
                if (cnt_done) begin
                    state_d  = RUN_STATE_RUNNING;
                    run_id_d = run_id_q + RUNID_BITS'(1);
                end
            end
            default: ;
        endcase

        // Only the highest-priority flag is considered; losers vanish silently.
        if (run_bus.runstop_i) begin
            if (state_q != RUN_STATE_IDLE) begin
                state_d  = RUN_STATE_IDLE;
                sync_d   = 1'b0;
                cnt_load = 1'b0;
                run_id_d = run_id_q;
            end
        end else if (run_bus.runrst_i) begin
            if (state_q == RUN_STATE_SYNCED || state_q == RUN_STATE_RUNNING) begin
                cnt_load = 1'b1;
                if (dly_zero) begin
                    state_d      = RUN_STATE_RST_HOLD;
                    cnt_load_val = HOLD_LOAD;
                end else begin
                    state_d      = RUN_STATE_RST_WAIT;
                    cnt_load_val = dly - CNT_W'(1);
                end
            end else begin
                err_d = 1'b1;
            end
        end else if (run_bus.rundosync_i) begin
            if (state_q == RUN_STATE_IDLE || state_q == RUN_STATE_SYNCED ||
                state_q == RUN_STATE_RUNNING) begin
                state_d      = RUN_STATE_SYNC_WAIT;
                cnt_load     = 1'b1;
                cnt_load_val = dly;
                sync_d       = dly_zero;
            end else begin
                err_d = 1'b1;
            end
        end

        run_rst_d = (state_d == RUN_STATE_RST_HOLD);
        running_d = (state_d == RUN_STATE_RUNNING);
    end

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= RUN_STATE_IDLE;
            sync_q    <= 1'b0;
            run_rst_q <= 1'b0;
            running_q <= 1'b0;
            err_q     <= 1'b0;
            run_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            run_rst_q <= run_rst_d;
            running_q <= running_d;
            err_q     <= err_d;
            run_id_q  <= run_id_d;
        end
    end

    assign run_bus.sync_o    = sync_q;
    assign run_bus.run_rst_o = run_rst_q;
    assign run_bus.running_o = running_q;
    assign run_bus.state_o   = state_q;
    assign run_bus.run_id_o  = run_id_q;
    assign run_bus.cmd_err_o = err_q;
endmodule
